// File: rtl/sha_mining_controller_if.sv
// Job, status and dual-engine handshake signals of the mining controller.
// The slave modport is the controller's view; master is the host/engine side.
interface sha_mining_controller_if;
  logic         start;
  logic         abort;
  logic [607:0] header_prefix;
  logic [255:0] target;
  logic [31:0]  nonce_start;
  logic [31:0]  nonce_end;

  logic [639:0] sha1_msg;
  logic         sha1_begin;
  logic         sha1_done;
  logic [255:0] sha1_hash;
  logic [255:0] sha2_msg;
  logic         sha2_begin;
  logic         sha2_done;
  logic [255:0] sha2_hash;

  logic         busy;
  logic         found;
  logic         exhausted;
  logic         error;
  logic         done;
  logic [31:0]  result_nonce;
  logic [255:0] result_hash;
  logic [31:0]  hashes_tried;

  modport slave (
    input  start, abort, header_prefix, target, nonce_start, nonce_end,
    input  sha1_done, sha1_hash, sha2_done, sha2_hash,
    output sha1_msg, sha1_begin, sha2_msg, sha2_begin,
    output busy, found, exhausted, error, done, result_nonce, result_hash, hashes_tried
  );

  modport master (
    output start, abort, header_prefix, target, nonce_start, nonce_end,
    output sha1_done, sha1_hash, sha2_done, sha2_hash,
    input  sha1_msg, sha1_begin, sha2_msg, sha2_begin,
    input  busy, found, exhausted, error, done, result_nonce, result_hash, hashes_tried
  );
endinterface

// File: rtl/sha_mining_controller.sv
// Double-SHA nonce search sequencer: walks an inclusive (possibly wrapping) nonce range,
// driving two external hash engines and stopping on a hash below target, range end or timeout.
module sha_mining_controller #(
  parameter int unsigned WATCHDOG_CYCLES = 1023
) (
  input logic                    clk,
  input logic                    rst,
  sha_mining_controller_if.slave mining_io
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad1,
    StWait1,
    StLoad2,
    StWait2,
    StCheck,
    StFin
  } state_e;

  state_e       state_q;
  logic [607:0] prefix_q;
  logic [255:0] target_q;
  logic [31:0]  nonce_q;
  logic [31:0]  nonce_end_q;
  logic [255:0] sha2_msg_q;
  logic [255:0] cand_hash_q;
  logic [255:0] result_hash_q;
  logic [31:0]  result_nonce_q;
  logic [31:0]  hashes_tried_q;
  logic [31:0]  wd_q;
  logic         sha1_begin_q;
  logic         sha2_begin_q;
  logic         busy_q;
  logic         found_q;
  logic         exhausted_q;
  logic         error_q;
  logic         done_q;

  logic [31:0] tried_inc;
  logic        wd_expired;
  logic        abort_ok;

  assign tried_inc  = (hashes_tried_q == 32'hFFFF_FFFF) ? hashes_tried_q
                                                         : hashes_tried_q + 32'd1;
  assign wd_expired = (wd_q == WATCHDOG_CYCLES - 1);
  assign abort_ok   = mining_io.abort && (state_q != StIdle) && (state_q != StFin);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      prefix_q       <= '0;
      target_q       <= '0;
      nonce_q        <= '0;
      nonce_end_q    <= '0;
      sha2_msg_q     <= '0;
      cand_hash_q    <= '0;
      result_hash_q  <= '0;
      result_nonce_q <= '0;
      hashes_tried_q <= '0;
      wd_q           <= '0;
      sha1_begin_q   <= 1'b0;
      sha2_begin_q   <= 1'b0;
      busy_q         <= 1'b0;
      found_q        <= 1'b0;
      exhausted_q    <= 1'b0;
      error_q        <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      sha1_begin_q <= 1'b0;
      sha2_begin_q <= 1'b0;
      done_q       <= 1'b0;
      if (abort_ok) begin
        // Abort beats any same-cycle engine done; only a completed CHECK still counts.
        if (state_q == StCheck) hashes_tried_q <= tried_inc;
        found_q     <= 1'b0;
        exhausted_q <= 1'b0;
        error_q     <= 1'b0;
        done_q      <= 1'b1;
        state_q     <= StFin;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (mining_io.start) begin
              prefix_q       <= mining_io.header_prefix;
              target_q       <= mining_io.target;
              nonce_q        <= mining_io.nonce_start;
              nonce_end_q    <= mining_io.nonce_end;
              found_q        <= 1'b0;
              exhausted_q    <= 1'b0;
              error_q        <= 1'b0;
              hashes_tried_q <= '0;
              busy_q         <= 1'b1;
              sha1_begin_q   <= 1'b1;
              state_q        <= StLoad1;
            end
          end
          StLoad1: begin
            wd_q    <= '0;
            state_q <= StWait1;
          end
          StWait1: begin
            if (mining_io.sha1_done) begin
              sha2_msg_q   <= mining_io.sha1_hash;
              sha2_begin_q <= 1'b1;
              state_q      <= StLoad2;
            end else if (wd_expired) begin
              error_q <= 1'b1;
              done_q  <= 1'b1;
              state_q <= StFin;
            end else begin
              wd_q <= wd_q + 32'd1;
            end
          end
          StLoad2: begin
            wd_q    <= '0;
            state_q <= StWait2;
          end
          StWait2: begin
            if (mining_io.sha2_done) begin
              cand_hash_q <= mining_io.sha2_hash;
              state_q     <= StCheck;
            end else if (wd_expired) begin
              error_q <= 1'b1;
              done_q  <= 1'b1;
              state_q <= StFin;
            end else begin
              wd_q <= wd_q + 32'd1;
            end
          end
          StCheck: begin
            hashes_tried_q <= tried_inc;
            result_hash_q  <= cand_hash_q;
            result_nonce_q <= nonce_q;
            if (cand_hash_q < target_q) begin
              found_q <= 1'b1;
              done_q  <= 1'b1;
              state_q <= StFin;
            end else if (nonce_q == nonce_end_q) begin
              exhausted_q <= 1'b1;
              done_q      <= 1'b1;
              state_q     <= StFin;
            end else begin
              nonce_q      <= nonce_q + 32'd1;
              sha1_begin_q <= 1'b1;
              state_q      <= StLoad1;
            end
          end
          StFin: begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign mining_io.sha1_msg     = {prefix_q, nonce_q};
  assign mining_io.sha1_begin   = sha1_begin_q;
  assign mining_io.sha2_msg     = sha2_msg_q;
  assign mining_io.sha2_begin   = sha2_begin_q;
  assign mining_io.busy         = busy_q;
  assign mining_io.found        = found_q;
  assign mining_io.exhausted    = exhausted_q;
  assign mining_io.error        = error_q;
  assign mining_io.done         = done_q;
  assign mining_io.result_nonce = result_nonce_q;
  assign mining_io.result_hash  = result_hash_q;
  assign mining_io.hashes_tried = hashes_tried_q;

endmodule

// File: tb/tb_sha_mining_controller.sv
// Bench for sha_mining_controller: mock hash engines, a nonce-search reference model,
// directed corner cases and randomized jobs.
module tb_sha_mining_controller;
  localparam int unsigned Wd = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sha_mining_controller_if mining ();

  sha_mining_controller #(.WATCHDOG_CYCLES(Wd)) dut (
    .clk       (clk),
    .rst       (rst),
    .mining_io (mining)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned lat1 = 70;
  int unsigned lat2 = 70;
  bit          e1_mute = 1'b0;
  bit          win_mode = 1'b0;
  logic [31:0] win_nonce = 32'h0;

  // Mock engine transfer functions; the nonce survives into the first hash's low word.
  function automatic logic [255:0] f1(input logic [639:0] m);
    return {m[255:32] ^ m[639:416], m[31:0]};
  endfunction

  function automatic logic [255:0] f2(input logic [255:0] m);
    if (win_mode) return (m[31:0] == win_nonce) ? 256'h1 : {256{1'b1}};
    return {m[31:0] * 32'h9E37_79B1, m[255:32]};
  endfunction

  int unsigned  e1_cnt = 0;
  int unsigned  e2_cnt = 0;
  logic [639:0] e1_msg;
  logic [255:0] e2_msg;

  always @(negedge clk) begin
    mining.sha1_done <= 1'b0;
    if (mining.sha1_begin === 1'b1 && !e1_mute) begin
      e1_cnt <= lat1;
      e1_msg <= mining.sha1_msg;
    end else if (e1_cnt > 0) begin
      e1_cnt <= e1_cnt - 1;
      if (e1_cnt == 1) begin
        mining.sha1_done <= 1'b1;
        mining.sha1_hash <= f1(e1_msg);
      end
    end
  end

  always @(negedge clk) begin
    mining.sha2_done <= 1'b0;
    if (mining.sha2_begin === 1'b1) begin
      e2_cnt <= lat2;
      e2_msg <= mining.sha2_msg;
    end else if (e2_cnt > 0) begin
      e2_cnt <= e2_cnt - 1;
      if (e2_cnt == 1) begin
        mining.sha2_done <= 1'b1;
        mining.sha2_hash <= f2(e2_msg);
      end
    end
  end

  int unsigned b1_cnt = 0, b2_cnt = 0, done_cnt = 0, b1_cyc = 0, done_cyc = 0;
  logic [31:0] seen[$];

  always @(negedge clk) begin
    if (mining.sha1_begin === 1'b1) begin
      b1_cnt <= b1_cnt + 1;
      b1_cyc <= cyc;
      seen.push_back(mining.sha1_msg[31:0]);
    end
    if (mining.sha2_begin === 1'b1) b2_cnt <= b2_cnt + 1;
    if (mining.done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  logic [31:0]  exp_seq[$];
  logic [31:0]  last_nonce = '0;
  logic [255:0] last_hash  = '0;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: try nonces in order from start, stop on hash < target or on the end nonce.
  task automatic model(input logic [607:0] p, input logic [255:0] t,
                       input logic [31:0] ns, input logic [31:0] ne,
                       output bit fnd, output bit exh, output logic [31:0] rn,
                       output logic [255:0] rh, output int unsigned tried);
    logic [31:0]  n;
    logic [255:0] h;
    n = ns;
    fnd = 1'b0;
    exh = 1'b0;
    rn = '0;
    rh = '0;
    tried = 0;
    exp_seq.delete();
    for (int k = 0; k < 64; k++) begin
      h = f2(f1({p, n}));
      tried++;
      exp_seq.push_back(n);
      rn = n;
      rh = h;
      if (h < t) begin
        fnd = 1'b1;
        break;
      end
      if (n == ne) begin
        exh = 1'b1;
        break;
      end
      n = n + 32'd1;
    end
  endtask

  task automatic start_job(input logic [607:0] p, input logic [255:0] t,
                           input logic [31:0] ns, input logic [31:0] ne);
    mining.header_prefix = p;
    mining.target        = t;
    mining.nonce_start   = ns;
    mining.nonce_end     = ne;
    mining.start         = 1'b1;
    tick();
    mining.start         = 1'b0;
  endtask

  task automatic wait_done(input int unsigned d0, input int unsigned limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      tick();
      if (done_cnt != d0) ok = 1'b1;
    end
  endtask

  task automatic check_zero(input string tag);
    check($sformatf("%s:busy", tag), mining.busy, 0);
    check($sformatf("%s:found", tag), mining.found, 0);
    check($sformatf("%s:exhausted", tag), mining.exhausted, 0);
    check($sformatf("%s:error", tag), mining.error, 0);
    check($sformatf("%s:done", tag), mining.done, 0);
    check($sformatf("%s:sha1_begin", tag), mining.sha1_begin, 0);
    check($sformatf("%s:sha2_begin", tag), mining.sha2_begin, 0);
    check($sformatf("%s:result_nonce", tag), mining.result_nonce, 0);
    check($sformatf("%s:result_hash", tag), mining.result_hash, 0);
    check($sformatf("%s:hashes_tried", tag), mining.hashes_tried, 0);
    check($sformatf("%s:sha1_msg", tag), mining.sha1_msg, 0);
    check($sformatf("%s:sha2_msg", tag), mining.sha2_msg, 0);
  endtask

  task automatic run_and_check(input string tag, input logic [607:0] p, input logic [255:0] t,
                               input logic [31:0] ns, input logic [31:0] ne, input bit poke);
    bit           fnd, exh, ok;
    logic [31:0]  rn;
    logic [255:0] rh;
    int unsigned  tried, b1_0, b2_0, d0, q0;
    model(p, t, ns, ne, fnd, exh, rn, rh, tried);
    b1_0 = b1_cnt;
    b2_0 = b2_cnt;
    d0   = done_cnt;
    q0   = seen.size();
    start_job(p, t, ns, ne);
    if (poke) begin
      for (int i = 0; i < 8; i++) begin
        mining.start         = 1'b1;
        mining.header_prefix = ~p;
        mining.nonce_start   = ns + 32'd7;
        tick();
        check($sformatf("%s:msg_stable%0d", tag, i), mining.sha1_msg, {p, ns});
      end
      mining.start = 1'b0;
    end
    wait_done(d0, 5000, ok);
    check($sformatf("%s:done_seen", tag), ok, 1);
    tick();
    tick();
    check($sformatf("%s:found", tag), mining.found, fnd);
    check($sformatf("%s:exhausted", tag), mining.exhausted, exh);
    check($sformatf("%s:error", tag), mining.error, 0);
    check($sformatf("%s:result_nonce", tag), mining.result_nonce, rn);
    check($sformatf("%s:result_hash", tag), mining.result_hash, rh);
    check($sformatf("%s:hashes_tried", tag), mining.hashes_tried, tried);
    check($sformatf("%s:sha1_begins", tag), b1_cnt - b1_0, tried);
    check($sformatf("%s:sha2_begins", tag), b2_cnt - b2_0, tried);
    check($sformatf("%s:done_pulses", tag), done_cnt - d0, 1);
    check($sformatf("%s:busy_after", tag), mining.busy, 0);
    check($sformatf("%s:seq_len", tag), seen.size() - q0, exp_seq.size());
    if (seen.size() - q0 == exp_seq.size()) begin
      foreach (exp_seq[i]) check($sformatf("%s:seq%0d", tag, i), seen[q0 + i], exp_seq[i]);
    end
    last_nonce = rn;
    last_hash  = rh;
  endtask

  function automatic logic [607:0] rand_prefix();
    logic [607:0] p;
    for (int i = 0; i < 19; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  initial begin
    logic [607:0] p;
    logic [255:0] t;
    logic [31:0]  ns;
    bit           ok, seen_d2;
    int unsigned  b1_0, b2_0, d0;

    mining.start         = 1'b0;
    mining.abort         = 1'b0;
    mining.header_prefix = '0;
    mining.target        = '0;
    mining.nonce_start   = '0;
    mining.nonce_end     = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_zero("reset");

    p = rand_prefix();
    run_and_check("single", p, {256{1'b1}}, 32'h5, 32'h5, 1'b0);
    run_and_check("wrap", rand_prefix(), '0, 32'hFFFF_FFFE, 32'h1, 1'b0);

    win_mode  = 1'b1;
    win_nonce = 32'h12;
    run_and_check("hit12", rand_prefix(), 256'h2, 32'h10, 32'h20, 1'b0);
    win_mode  = 1'b0;

    lat1 = 20;
    lat2 = 20;
    run_and_check("busy_start", rand_prefix(), '0, 32'h40, 32'h41, 1'b1);

    for (int r = 0; r < 6; r++) begin
      lat1 = $urandom_range(1, 12);
      lat2 = $urandom_range(1, 12);
      t    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      ns   = $urandom;
      run_and_check($sformatf("rand%0d", r), rand_prefix(), t, ns,
                    ns + $urandom_range(0, 5), 1'b0);
    end

    e1_mute = 1'b1;
    d0 = done_cnt;
    start_job(rand_prefix(), {256{1'b1}}, 32'h7, 32'h9);
    wait_done(d0, Wd + 50, ok);
    check("wd:done_seen", ok, 1);
    check("wd:done_cycle", done_cyc - b1_cyc, Wd + 1);
    tick();
    tick();
    check("wd:error", mining.error, 1);
    check("wd:found", mining.found, 0);
    check("wd:exhausted", mining.exhausted, 0);
    check("wd:result_nonce", mining.result_nonce, last_nonce);
    check("wd:done_pulses", done_cnt - d0, 1);
    e1_mute = 1'b0;

    lat1 = 6;
    lat2 = 10;
    b1_0 = b1_cnt;
    b2_0 = b2_cnt;
    d0   = done_cnt;
    start_job(rand_prefix(), '0, 32'h100, 32'h103);
    seen_d2 = 1'b0;
    for (int i = 0; i < 500 && !seen_d2; i++) begin
      tick();
      if (mining.sha2_done === 1'b1) seen_d2 = 1'b1;
    end
    check("abort:sha2_done_seen", seen_d2, 1);
    mining.abort = 1'b1;
    tick();
    mining.abort = 1'b0;
    check("abort:done", mining.done, 1);
    check("abort:busy_fin", mining.busy, 1);
    check("abort:found", mining.found, 0);
    check("abort:exhausted", mining.exhausted, 0);
    check("abort:error", mining.error, 0);
    check("abort:result_nonce", mining.result_nonce, last_nonce);
    check("abort:result_hash", mining.result_hash, last_hash);
    repeat (3) tick();
    check("abort:done_pulses", done_cnt - d0, 1);
    check("abort:busy_after", mining.busy, 0);
    check("abort:sha1_begins", b1_cnt - b1_0, 1);
    check("abort:sha2_begins", b2_cnt - b2_0, 1);

    lat1 = 70;
    lat2 = 70;
    b1_0 = b1_cnt;
    d0   = done_cnt;
    start_job(rand_prefix(), {256{1'b1}}, 32'h55, 32'h56);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero("midreset");
    repeat (90) tick();
    check("midreset:done_pulses", done_cnt - d0, 0);
    check("midreset:sha1_begins", b1_cnt - b1_0, 1);
    check("midreset:busy", mining.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sha_mining_controller.md
SHA_MINING_CONTROLLER -- requirements
Module: sha_mining_controller

Interface
REQ-001 Parameter WATCHDOG_CYCLES, default 1023: max cycles waited for an engine done before abandoning the job.
REQ-002 Port clk  input  1  rising-edge clock; all state changes on this edge only.
REQ-003 Port rst  input  1  synchronous, active-high reset.
REQ-004 Port start  input  1  job request; sampled in IDLE only.
REQ-005 Port abort  input  1  cancel the running job.
REQ-006 Port header_prefix  input  608  block header minus nonce; latched on start.
REQ-007 Port target  input  256  unsigned threshold; latched on start.
REQ-008 Ports nonce_start, nonce_end  input  32 each  inclusive nonce range; latched on start.
REQ-009 Ports sha1_msg output 640, sha1_begin output 1, sha1_done input 1, sha1_hash input 256: first-pass engine (640-bit message).
REQ-010 Ports sha2_msg output 256, sha2_begin output 1, sha2_done input 1, sha2_hash input 256: second-pass engine (256-bit message).
REQ-011 Ports busy, found, exhausted, error, done  output  1 each: status; done is a 1-cycle pulse.
REQ-012 Ports result_nonce output 32, result_hash output 256, hashes_tried output 32: job results.

Function
REQ-013 FSM states SHALL be IDLE, LOAD1, WAIT1, LOAD2, WAIT2, CHECK, FIN; all transitions registered.
REQ-014 IDLE + start: latch inputs, nonce <= nonce_start, clear found/exhausted/error/hashes_tried, go LOAD1; start in any other state ignored.
REQ-015 sha1_msg SHALL equal {header_prefix latch, nonce}, nonce in bits [31:0], and be stable from LOAD1 until leaving WAIT1.
REQ-016 LOAD1: sha1_begin = 1 for exactly that cycle; go WAIT1.
REQ-017 WAIT1: on sha1_done, capture sha1_hash into sha2_msg and go LOAD2; sha2_msg held stable until leaving WAIT2.
REQ-018 LOAD2: sha2_begin = 1 for exactly that cycle; go WAIT2.
REQ-019 WAIT2: on sha2_done, capture sha2_hash into result_hash, nonce into result_nonce, go CHECK.
REQ-020 CHECK: increment hashes_tried (saturating at 0xFFFFFFFF); if result_hash < target (unsigned, 256-bit) set found, go FIN; else if nonce == nonce_end set exhausted, go FIN; else nonce <= nonce + 1 (mod 2^32), go LOAD1.
REQ-021 Range wraps: nonce_end < nonce_start SHALL iterate through 0xFFFFFFFF to 0x00000000; nonce_start == nonce_end SHALL try exactly one nonce.
REQ-022 Per-nonce overhead SHALL be 3 controller cycles (LOAD1, LOAD2, CHECK) plus both engine latencies.
REQ-023 Watchdog counter clears on entering WAIT1/WAIT2; reaching WATCHDOG_CYCLES without the matching done sets error, go FIN.
REQ-024 done/begin from the engine not being waited on SHALL be ignored.
REQ-025 abort in any state except IDLE/FIN: go FIN next cycle with found = exhausted = error = 0; no further begin pulses.
REQ-026 Same-cycle abort with sha*_done or in CHECK: abort wins; captured result discarded except hashes_tried.
REQ-027 FIN: done = 1 one cycle, go IDLE; found/exhausted/error/result_* held until next accepted start.
REQ-028 busy = 1 in every state except IDLE.

Reset
REQ-029 rst SHALL force IDLE next edge from any state, overriding start/abort.
REQ-030 After reset all outputs = 0: busy, found, exhausted, error, done, sha1_begin, sha2_begin, result_nonce, result_hash, hashes_tried, sha1_msg, sha2_msg.
REQ-031 Reset mid-job SHALL not emit done; in-flight engine done pulses after reset ignored.

Verification (mock engines, done 70 cycles after begin unless stated)
REQ-032 target = all-ones, nonce_start = nonce_end = 0x00000005, start -> one sha1_begin, one sha2_begin, found=1, result_nonce=0x5, hashes_tried=1, single done pulse.
REQ-033 target = 0, nonce_start=0xFFFFFFFE, nonce_end=0x00000001 -> nonces FFFFFFFE,FFFFFFFF,0,1 tried, exhausted=1, result_nonce=0x1, hashes_tried=4.
REQ-034 Mock sha2_hash < target only for nonce 0x12, range 0x10..0x20 -> found at 0x12, hashes_tried=3, no begin after CHECK of 0x12.
REQ-035 sha1_done never asserted -> error=1, done exactly WATCHDOG_CYCLES cycles after entering WAIT1 (+1 FIN), found=exhausted=0.
REQ-036 abort in WAIT2 coincident with sha2_done -> FIN next cycle, found=0, result_* unchanged, done pulse once; rst asserted in WAIT1 -> all outputs 0, no done.
REQ-037 start pulsed while busy and sha1_msg sampled every WAIT1 cycle -> start ignored, message constant.
